perceptron_ctrl: RTL and testbench



---
 rtl/perceptron_ctrl_if.sv | 33 +++
 rtl/perceptron_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_perceptron_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/perceptron_ctrl_if.sv
// UART/core-side bundle for perceptron_ctrl: rx byte stream, tx byte stream,
// core register-file write port and compute handshake.
interface perceptron_ctrl_if #(
   parameter int unsigned N_INPUTS = 2,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned RESULT_W = 16
);
   localparam int unsigned ADDR_W = $clog2(N_INPUTS);

   logic                rx_valid;
   logic [7:0]          rx_data;
   logic                tx_busy;
   logic                tx_start;
   logic [7:0]          tx_data;
   logic                wr_en;
   logic                wr_sel;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic                start;
   logic                done;
   logic [RESULT_W-1:0] result;

   // master = the sequencer, slave = UART plus core
   modport master (
      input  rx_valid, rx_data, tx_busy, done, result,
      output tx_start, tx_data, wr_en, wr_sel, wr_addr, wr_data, start
   );

   modport slave (
      output rx_valid, rx_data, tx_busy, done, result,
      input  tx_start, tx_data, wr_en, wr_sel, wr_addr, wr_data, start
   );
endinterface

// File: rtl/perceptron_ctrl.sv
// Byte command sequencer between UART and perceptron core.
// Optional inter-byte/compute timeout enabled by defining PCTRL_TIMEOUT_EN.
module perceptron_ctrl #(
   parameter int unsigned N_INPUTS    = 2,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned RESULT_W    = 16,
   parameter int unsigned TIMEOUT_CYC = 43500
) (
   input  logic              clk,
   input  logic              nRst,
   perceptron_ctrl_if.master bus
);
   localparam int unsigned ADDR_W  = $clog2(N_INPUTS);
   localparam int unsigned N_BYTES = RESULT_W / 8;
   localparam int unsigned LEFT_W  = $clog2(N_BYTES + 1);

   localparam logic [7:0] CMD_LOAD_W = 8'h80;
   localparam logic [7:0] CMD_LOAD_X = 8'h81;
   localparam logic [7:0] CMD_RUN    = 8'h82;
   localparam logic [7:0] CMD_STATUS = 8'h83;

   if (DATA_W != 8 || RESULT_W == 0 || (RESULT_W % 8) != 0 ||
       N_INPUTS < 2 || N_INPUTS > 16 || TIMEOUT_CYC == 0) begin : g_param_check
      $error("perceptron_ctrl: illegal parameter set");
   end

   typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT_DONE, SEND, SEND_WAIT} state_t;

   state_t              state_q, state_d;
   logic                sel_q, sel_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [RESULT_W-1:0] shift_q, shift_d;
   logic [LEFT_W-1:0]   left_q, left_d;
   logic                skip_q, skip_d;
   logic                bad_cmd_q, overrun_q, timeout_q;
   logic                bad_cmd_set, overrun_set, timeout_set, flag_clr;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                start_q, start_d;
   logic                tx_start_q, tx_start_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                tmo_expired;
   logic [7:0]          status_byte;

   assign status_byte = {5'b0, timeout_q, overrun_q, bad_cmd_q};

`ifdef PCTRL_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] tmo_cnt_q;
   logic             tmo_run;

   // Counts idle cycles in LOAD (reloaded by each byte) and cycles in WAIT_DONE
   assign tmo_run     = (state_q == LOAD) || (state_q == WAIT_DONE);
   assign tmo_expired = tmo_run && (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst)                                      tmo_cnt_q <= '0;
      else if (!tmo_run || (state_q == LOAD && bus.rx_valid)) tmo_cnt_q <= '0;
      else                                            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
   end
`else
   assign tmo_expired = 1'b0;
`endif

   // Next-state and registered-output decode
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      left_d      = left_q;
      skip_d      = 1'b0;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      start_d     = 1'b0;
      tx_start_d  = 1'b0;
      tx_data_d   = tx_data_q;
      bad_cmd_set = 1'b0;
      overrun_set = 1'b0;
      timeout_set = 1'b0;
      flag_clr    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.rx_valid) begin
               unique case (bus.rx_data)
                  CMD_LOAD_W, CMD_LOAD_X: begin
                     state_d = LOAD;
                     sel_d   = bus.rx_data[0];
                     idx_d   = '0;
                  end
                  CMD_RUN: begin
                     state_d = RUN;
                     start_d = 1'b1;
                  end
                  CMD_STATUS: begin
                     shift_d  = RESULT_W'(status_byte) << (RESULT_W - 8);
                     left_d   = LEFT_W'(1);
                     flag_clr = 1'b1;
                     state_d  = SEND;
                  end
                  default: bad_cmd_set = 1'b1;
               endcase
            end
         end
         LOAD: begin
            if (bus.rx_valid) begin
               wr_en_d   = 1'b1;
               wr_addr_d = idx_q;
               wr_data_d = DATA_W'(bus.rx_data);
               idx_d     = idx_q + ADDR_W'(1);
               if (idx_q == ADDR_W'(N_INPUTS - 1)) state_d = IDLE;
            end else if (tmo_expired) begin
               timeout_set = 1'b1;
               state_d     = IDLE;
            end
         end
         RUN: state_d = WAIT_DONE;
         WAIT_DONE: begin
            if (bus.done) begin
               shift_d = bus.result;
               left_d  = LEFT_W'(N_BYTES);
               state_d = SEND;
            end else if (tmo_expired) begin
               timeout_set = 1'b1;
               state_d     = IDLE;
            end
         end
         SEND: begin
            if (!bus.tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = shift_q[RESULT_W-1 -: 8];
               skip_d     = 1'b1;
               state_d    = SEND_WAIT;
            end
         end
         SEND_WAIT: begin
            // tx_busy only rises one cycle after tx_start, so ignore the first cycle
            if (!skip_q && !bus.tx_busy) begin
               shift_d = shift_q << 8;
               left_d  = left_q - LEFT_W'(1);
               state_d = (left_q > LEFT_W'(1)) ? SEND : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (bus.rx_valid && (state_q == RUN || state_q == WAIT_DONE ||
                           state_q == SEND || state_q == SEND_WAIT))
         overrun_set = 1'b1;
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q    <= IDLE;
         sel_q      <= 1'b0;
         idx_q      <= '0;
         shift_q    <= '0;
         left_q     <= '0;
         skip_q     <= 1'b0;
         bad_cmd_q  <= 1'b0;
         overrun_q  <= 1'b0;
         timeout_q  <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         start_q    <= 1'b0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         left_q     <= left_d;
         skip_q     <= skip_d;
         bad_cmd_q  <= (bad_cmd_q & ~flag_clr) | bad_cmd_set;
         overrun_q  <= (overrun_q & ~flag_clr) | overrun_set;
         timeout_q  <= (timeout_q & ~flag_clr) | timeout_set;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         start_q    <= start_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign bus.wr_en    = wr_en_q;
   assign bus.wr_sel   = sel_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.start    = start_q;
   assign bus.tx_start = tx_start_q;
   assign bus.tx_data  = tx_data_q;
endmodule

// File: tb/tb_perceptron_ctrl.sv
// Self-checking bench for perceptron_ctrl: UART tx and core modelled here,
// expectations derived from a transaction-level command model.
module tb_perceptron_ctrl;
   localparam int unsigned N_INPUTS = 2;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned RESULT_W = 16;
   localparam int unsigned TMO      = 300;
   localparam int unsigned N_BYTES  = RESULT_W / 8;

   logic clk  = 1'b0;
   logic nRst = 1'b1;

   perceptron_ctrl_if #(.N_INPUTS(N_INPUTS), .DATA_W(DATA_W), .RESULT_W(RESULT_W)) bus ();

   perceptron_ctrl #(
      .N_INPUTS(N_INPUTS), .DATA_W(DATA_W), .RESULT_W(RESULT_W), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk), .nRst(nRst), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       sel;
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   int checks = 0;
   int errors = 0;

   // monitor results
   wr_t        wr_q[$];
   logic [7:0] tx_q[$];
   int         start_cnt, tx_overlap, tx_lat;
   bit         lat_seen;
   longint     cyc, done_cyc;

   // peer models
   bit                  core_mute, core_pending, busy_pending;
   int                  core_cd, run_delay, busy_left;
   logic [RESULT_W-1:0] core_res;

   // command-level reference state
   bit         m_bad, m_ovr, m_tmo;
   logic [7:0] ld_q[$];

   always @(negedge clk) begin
      wr_t w;
      cyc++;
      if (bus.wr_en) begin
         w.sel = bus.wr_sel; w.addr = 8'(bus.wr_addr); w.data = bus.wr_data;
         wr_q.push_back(w);
      end
      if (bus.start) begin
         start_cnt++;
         if (!core_mute) begin core_pending = 1; core_cd = run_delay; end
      end
      if (bus.done) done_cyc = cyc;
      if (bus.tx_start) begin
         tx_q.push_back(bus.tx_data);
         if (bus.tx_busy) tx_overlap++;
         if (!lat_seen) begin tx_lat = int'(cyc - done_cyc); lat_seen = 1; end
         busy_pending = 1;
      end
   end

   // core and UART tx behaviour
   initial begin
      bus.done = 0; bus.result = '0; bus.tx_busy = 0;
      forever begin
         @(posedge clk); #1;
         bus.done = 0;
         if (core_pending) begin
            if (core_cd == 0) begin bus.done = 1; bus.result = core_res; core_pending = 0; end
            else core_cd--;
         end
         if (busy_pending) begin
            bus.tx_busy = 1; busy_left = $urandom_range(3, 12); busy_pending = 0;
         end else if (bus.tx_busy) begin
            if (busy_left <= 1) bus.tx_busy = 0; else busy_left--;
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_data = b; bus.rx_valid = 1;
      tick(1);
      bus.rx_valid = 0; bus.rx_data = 8'($urandom);
   endtask

   task automatic clear_mon();
      wr_q.delete(); tx_q.delete();
      start_cnt = 0; tx_overlap = 0; lat_seen = 0;
   endtask

   task automatic wait_tx(input int n, input string tag);
      int budget = 4000;
      while (tx_q.size() < n && budget > 0) begin tick(1); budget--; end
      checks++;
      if (budget === 0) begin
         errors++;
         $display("FAIL %s tx_wait: got %0d bytes, need %0d", tag, tx_q.size(), n);
      end
      tick(2);
      budget = 100;
      while (bus.tx_busy && budget > 0) begin tick(1); budget--; end
      tick(3);
   endtask

   task automatic do_load(input bit sel, input int gap_max, input string tag);
      clear_mon();
      send_byte(sel ? 8'h81 : 8'h80);
      for (int i = 0; i < N_INPUTS; i++) begin
         tick($urandom_range(0, gap_max));
         send_byte(ld_q[i]);
      end
      tick(3);
      checks++;
      if (wr_q.size() !== N_INPUTS) begin
         errors++; $display("FAIL %s wr_count: got %0d, need %0d", tag, wr_q.size(), N_INPUTS);
      end
      for (int i = 0; i < N_INPUTS && i < wr_q.size(); i++) begin
         checks++;
         if ({wr_q[i].sel, wr_q[i].addr, wr_q[i].data} !== {sel, 8'(i), ld_q[i]}) begin
            errors++;
            $display("FAIL %s wr[%0d]: got sel%0d addr%0d %h, need sel%0d addr%0d %h", tag, i,
                     wr_q[i].sel, wr_q[i].addr, wr_q[i].data, sel, i, ld_q[i]);
         end
      end
      checks++;
      if ((tx_q.size() + start_cnt) !== 0) begin
         errors++; $display("FAIL %s load_side_effects: got %0d tx/start, need 0", tag, tx_q.size() + start_cnt);
      end
   endtask

   task automatic check_result(input logic [RESULT_W-1:0] res, input string tag);
      checks++;
      if (start_cnt !== 1) begin
         errors++; $display("FAIL %s start_count: got %0d, need 1", tag, start_cnt);
      end
      checks++;
      if (tx_q.size() !== N_BYTES) begin
         errors++; $display("FAIL %s tx_count: got %0d, need %0d", tag, tx_q.size(), N_BYTES);
      end
      for (int i = 0; i < N_BYTES && i < tx_q.size(); i++) begin
         logic [7:0] e;
         e = 8'(res >> (8 * (N_BYTES - 1 - i)));
         checks++;
         if (tx_q[i] !== e) begin
            errors++; $display("FAIL %s tx_byte[%0d]: got %h, need %h", tag, i, tx_q[i], e);
         end
      end
      checks++;
      if (tx_overlap !== 0) begin
         errors++; $display("FAIL %s tx_while_busy: got %0d, need 0", tag, tx_overlap);
      end
      checks++;
      if (tx_lat !== 2) begin
         errors++; $display("FAIL %s done_to_tx_latency: got %0d, need 2", tag, tx_lat);
      end
   endtask

   task automatic do_run(input logic [RESULT_W-1:0] res, input int dly, input string tag);
      clear_mon(); core_res = res; run_delay = dly;
      send_byte(8'h82);
      wait_tx(N_BYTES, tag);
      check_result(res, tag);
   endtask

   task automatic do_status(input string tag);
      logic [7:0] e, got;
      e = {5'b0, m_tmo, m_ovr, m_bad};
      clear_mon();
      send_byte(8'h83);
      wait_tx(1, tag);
      got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
      checks++;
      if (tx_q.size() !== 1 || got !== e) begin
         errors++; $display("FAIL %s status: got %h (%0d bytes), need %h", tag, got, tx_q.size(), e);
      end
      m_bad = 0; m_ovr = 0; m_tmo = 0;
   endtask

   task automatic do_bad(input logic [7:0] b, input string tag);
      clear_mon();
      send_byte(b);
      tick(3);
      checks++;
      if ((wr_q.size() + tx_q.size() + start_cnt) !== 0) begin
         errors++; $display("FAIL %s bad_cmd_side_effects: got %0d events, need 0", tag,
                            wr_q.size() + tx_q.size() + start_cnt);
      end
      m_bad = 1;
   endtask

   task automatic check_outputs_zero(input string tag);
      logic [31:0] got;
      got = {8'(bus.wr_en), 8'(bus.wr_sel), 8'(bus.wr_addr), bus.wr_data} |
            {8'(bus.start), 8'(bus.tx_start), bus.tx_data, 8'h00};
      checks++;
      if (got !== 32'h0) begin
         errors++; $display("FAIL %s outputs_in_reset: got %h, need 0", tag, got);
      end
   endtask

   task automatic test_reset();
      bus.rx_valid = 0; bus.rx_data = 0;
      #2 nRst = 0;
      tick(3);
      check_outputs_zero("reset");
      nRst = 1;
      m_bad = 0; m_ovr = 0; m_tmo = 0;
      tick(2);
      do_status("reset_status");
   endtask

   task automatic test_load_w();
      ld_q = '{8'h01, 8'hAA};
      do_load(0, 2, "load_w");
   endtask

   task automatic test_load_x_timeout();
      clear_mon();
      send_byte(8'h81); send_byte(8'h01);
      tick(TMO + 20);
`ifdef PCTRL_TIMEOUT_EN
      checks++;
      if (wr_q.size() !== 1 || {wr_q[0].sel, wr_q[0].addr, wr_q[0].data} !== {1'b1, 8'h00, 8'h01}) begin
         errors++; $display("FAIL load_timeout writes: got %0d writes, need 1 (sel1 addr0 01)", wr_q.size());
      end
      m_tmo = 1;
      do_status("load_timeout_status");
`else
      send_byte(8'h02);
      tick(3);
      checks++;
      if (wr_q.size() !== 2) begin
         errors++; $display("FAIL load_no_timeout wr_count: got %0d, need 2", wr_q.size());
      end else begin
         checks++;
         if ({wr_q[1].sel, wr_q[1].addr, wr_q[1].data} !== {1'b1, 8'h01, 8'h02}) begin
            errors++; $display("FAIL load_no_timeout wr[1]: got sel%0d addr%0d %h, need sel1 addr1 02",
                               wr_q[1].sel, wr_q[1].addr, wr_q[1].data);
         end
      end
`endif
   endtask

   task automatic test_run();
      do_run(16'h1234, 10, "run_1234");
      do_run(16'hFF00, 0, "run_ff00");
   endtask

   task automatic test_bad_cmd();
      do_bad(8'h55, "bad_55");
      do_status("bad_status1");
      do_status("bad_status2");
   endtask

   task automatic test_overrun();
      logic [RESULT_W-1:0] res;
      res = RESULT_W'($urandom);
      clear_mon(); core_res = res; run_delay = 20;
      send_byte(8'h82);
      tick(3);
      send_byte(8'h80);
      wait_tx(N_BYTES, "overrun");
      checks++;
      if (wr_q.size() !== 0) begin
         errors++; $display("FAIL overrun wr_count: got %0d, need 0", wr_q.size());
      end
      check_result(res, "overrun");
      m_ovr = 1;
      do_status("overrun_status");
   endtask

   task automatic test_wait_done_timeout();
      clear_mon(); core_mute = 1;
      send_byte(8'h82);
      tick(TMO + 20);
      checks++;
      if (tx_q.size() !== 0) begin
         errors++; $display("FAIL wait_done_idle tx_count: got %0d, need 0", tx_q.size());
      end
      core_mute = 0;
`ifdef PCTRL_TIMEOUT_EN
      m_tmo = 1;
      do_status("wait_timeout_status");
`else
      core_res = 16'hBEEF; core_cd = 0; core_pending = 1;
      wait_tx(N_BYTES, "wait_late_done");
      check_result(16'hBEEF, "wait_late_done");
`endif
   endtask

   task automatic test_reset_mid();
      clear_mon();
      send_byte(8'h80); send_byte(8'h07);
      tick(2);
      checks++;
      if (wr_q.size() !== 1) begin
         errors++; $display("FAIL reset_mid pre_writes: got %0d, need 1", wr_q.size());
      end
      nRst = 0;
      tick(1);
      check_outputs_zero("reset_mid");
      nRst = 1;
      m_bad = 0; m_ovr = 0; m_tmo = 0;
      tick(1);
      do_bad(8'h01, "reset_mid_01");
      do_status("reset_mid_status");
   endtask

   task automatic test_back_to_back();
      ld_q = '{8'hC3, 8'h80};
      do_load(0, 0, "b2b_w");
      ld_q = '{8'h83, 8'h7F};
      do_load(1, 0, "b2b_x");
      do_run(16'h00FF, 1, "b2b_run");
   endtask

   task automatic test_random();
      for (int it = 0; it < 40; it++) begin
         int op;
         op = $urandom_range(0, 4);
         case (op)
            0, 1: begin
               ld_q.delete();
               for (int i = 0; i < N_INPUTS; i++) ld_q.push_back(8'($urandom));
               do_load(op == 1, 3, "rand_load");
            end
            2: do_run(RESULT_W'($urandom), $urandom_range(0, 25), "rand_run");
            3: do_status("rand_status");
            default: begin
               logic [7:0] b;
               b = 8'($urandom);
               if (b >= 8'h80 && b <= 8'h83) b = b ^ 8'h40;
               do_bad(b, "rand_bad");
            end
         endcase
      end
   endtask

   initial begin
      core_mute = 0; core_pending = 0; busy_pending = 0; run_delay = 0;
      test_reset();
      test_load_w();
      test_load_x_timeout();
      test_run();
      test_bad_cmd();
      test_overrun();
      test_wait_done_timeout();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
